// File: rtl/pop_output_stage.sv
// Output stage of the POP pulse timer: registers raw pump/probe/MW/sample levels,
// gates them through run control, counts cycles and latches overlap/stall faults.
module pop_output_stage #(
    parameter int CW       = 16,
    parameter int WATCHDOG = 12000
) (
    input  logic          clock_2_5M,
    input  logic          reset,
    input  logic          pump_raw,
    input  logic          probe_raw,
    input  logic          mw_raw,
    input  logic          sample_raw,
    input  logic          start,
    input  logic          stop,
    input  logic          fault_clear,
    input  logic [CW-1:0] burst_len,
    output logic          pump,
    output logic          probe,
    output logic          MW,
    output logic          sample,
    output logic          timer_reset,
    output logic          running,
    output logic [CW-1:0] cycles_done,
    output logic          done,
    output logic          fault,
    output logic [2:0]    fault_code,
    output logic [2:0]    state_dbg
);

    localparam int WW = $clog2(WATCHDOG + 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ARM   = 3'd1,
        S_RUN   = 3'd2,
        S_DRAIN = 3'd3,
        S_FAULT = 3'd4
    } state_t;

    state_t        state, state_n;
    logic [CW-1:0] len_q;
    logic [CW-1:0] cnt_inc;
    logic [WW-1:0] wd_q;
    logic          active, complete, last, wd_hit;
    logic [2:0]    code_hit;
    logic          pass, done_d, timer_reset_d, running_d, fault_d;

    // A completion is a probe falling edge: the registered probe output is the
    // previous raw level while active, so it doubles as the edge detector.
    always_comb begin
        active   = (state == S_RUN) || (state == S_DRAIN);
        complete = active && probe && !probe_raw;
        cnt_inc  = (&cycles_done) ? cycles_done : cycles_done + 1'b1;
        last     = (len_q != '0) && (cnt_inc == len_q);
        wd_hit   = active && !complete && (wd_q == WW'(WATCHDOG - 1));
        code_hit = {wd_hit,
                    active && probe_raw && mw_raw,
                    active && pump_raw && mw_raw};
    end

    always_ff @(posedge clock_2_5M) begin
        if (reset) state <= S_IDLE;
        else       state <= state_n;
    end

    // Same-edge priority: fault, then completion, then stop.
    always_comb begin
        state_n = state;
        case (state)
            S_IDLE:  if (start && !stop) state_n = S_ARM;
            S_ARM:   state_n = stop ? S_IDLE : S_RUN;
            S_RUN: begin
                if (|code_hit)            state_n = S_FAULT;
                else if (complete && last) state_n = S_IDLE;
                else if (stop)            state_n = S_DRAIN;
            end
            S_DRAIN: begin
                if (|code_hit)     state_n = S_FAULT;
                else if (complete) state_n = S_IDLE;
            end
            S_FAULT: if (fault_clear) state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase
    end

    // Raw levels pass only while staying inside RUN/DRAIN; leaving loads zeros,
    // so an overlap never reaches the pins and ARM keeps the first cycle dark.
    always_comb begin
        pass          = active && ((state_n == S_RUN) || (state_n == S_DRAIN));
        done_d        = active && (state_n == S_IDLE);
        timer_reset_d = (state_n == S_IDLE) || (state_n == S_FAULT);
        running_d     = (state_n == S_ARM) || (state_n == S_RUN) || (state_n == S_DRAIN);
        fault_d       = (state_n == S_FAULT);
    end

    always_ff @(posedge clock_2_5M) begin
        if (reset) begin
            pump        <= 1'b0;
            probe       <= 1'b0;
            MW          <= 1'b0;
            sample      <= 1'b0;
            timer_reset <= 1'b1;
            running     <= 1'b0;
            done        <= 1'b0;
            fault       <= 1'b0;
            fault_code  <= 3'b000;
            cycles_done <= '0;
            len_q       <= '0;
            wd_q        <= '0;
        end else begin
            pump        <= pass && pump_raw;
            probe       <= pass && probe_raw;
            MW          <= pass && mw_raw;
            sample      <= pass && sample_raw;
            timer_reset <= timer_reset_d;
            running     <= running_d;
            done        <= done_d;
            fault       <= fault_d;

            if (state == S_IDLE && state_n == S_ARM) begin
                len_q       <= burst_len;
                cycles_done <= '0;
                wd_q        <= '0;
            end else if (active && !(|code_hit)) begin
                if (complete) begin
                    cycles_done <= cnt_inc;
                    wd_q        <= '0;
                end else begin
                    wd_q <= wd_q + 1'b1;
                end
            end

            if (state != S_FAULT && state_n == S_FAULT)
                fault_code <= code_hit;
            else if (state == S_FAULT && fault_clear)
                fault_code <= 3'b000;
        end
    end

    assign state_dbg = state;

endmodule

// File: tb/tb_pop_output_stage.sv
// Directed bench for pop_output_stage driven by a short-period timer model
// (pump 0-3, MW 6-9, probe 12-14, sample 13, period 20).
module tb_pop_output_stage;

    localparam int CW = 3;
    localparam int WD = 50;
    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_ARM   = 3'd1;
    localparam logic [2:0] ST_RUN   = 3'd2;
    localparam logic [2:0] ST_DRAIN = 3'd3;
    localparam logic [2:0] ST_FAULT = 3'd4;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic pump_raw, probe_raw, mw_raw, sample_raw;
    logic start, stop, fault_clear;
    logic [CW-1:0] burst_len;
    logic pump, probe, MW, sample, timer_reset, running, done, fault;
    logic [CW-1:0] cycles_done;
    logic [2:0] fault_code, state_dbg;

    logic force_mw, hold_probe_low;
    int tcnt = 0;
    int errors = 0;
    int checks = 0;
    logic [31:0] exp_q[$];

    pop_output_stage #(.CW(CW), .WATCHDOG(WD)) dut (
        .clock_2_5M (clk),
        .reset      (reset),
        .pump_raw   (pump_raw),
        .probe_raw  (probe_raw),
        .mw_raw     (mw_raw),
        .sample_raw (sample_raw),
        .start      (start),
        .stop       (stop),
        .fault_clear(fault_clear),
        .burst_len  (burst_len),
        .pump       (pump),
        .probe      (probe),
        .MW         (MW),
        .sample     (sample),
        .timer_reset(timer_reset),
        .running    (running),
        .cycles_done(cycles_done),
        .done       (done),
        .fault      (fault),
        .fault_code (fault_code),
        .state_dbg  (state_dbg)
    );

    // clock / reset
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL global_timeout: observed=running expected=finished");
        $fatal(1, "bench timeout");
    end

    // timer model: held at count 0 while timer_reset is high
    always @(posedge clk) begin
        if (timer_reset) tcnt <= 0;
        else             tcnt <= (tcnt == 19) ? 0 : tcnt + 1;
    end

    always_comb begin
        pump_raw   = (tcnt < 4);
        mw_raw     = ((tcnt >= 6) && (tcnt < 10)) || force_mw;
        probe_raw  = (tcnt >= 12) && (tcnt < 15) && !hold_probe_low;
        sample_raw = (tcnt == 13);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_values(input string tag);
        chk({tag, " state"}, 32'(state_dbg), 32'(ST_IDLE));
        chk({tag, " pins"}, {28'd0, pump, probe, MW, sample}, 32'd0);
        chk({tag, " timer_reset"}, 32'(timer_reset), 32'd1);
        chk({tag, " running"}, 32'(running), 32'd0);
        chk({tag, " cycles_done"}, 32'(cycles_done), 32'd0);
        chk({tag, " done"}, 32'(done), 32'd0);
        chk({tag, " fault"}, 32'(fault), 32'd0);
        chk({tag, " fault_code"}, 32'(fault_code), 32'd0);
    endtask

    // driver tasks: inputs change on the falling edge
    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_fault_clear();
        fault_clear = 1'b1;
        tick(1);
        fault_clear = 1'b0;
    endtask

    initial begin
        int done_at, dones, probes, mw_cycles, stop_j, fault_at;
        logic prev_probe;
        start = 0; stop = 0; fault_clear = 0; burst_len = '0;
        force_mw = 0; hold_probe_low = 0;

        tick(3);
        chk_reset_values("reset");
        reset = 1'b0;

        // idle pump suppression: timer presents pump_raw=1 while held
        for (int i = 0; i < 4; i++) begin
            tick(1);
            chk("idle pump", 32'(pump), 32'd0);
            chk("idle timer_reset", 32'(timer_reset), 32'd1);
        end

        // burst of 3: done seen on the 57th falling edge after start
        exp_q.push_back(32'd1); exp_q.push_back(32'd2); exp_q.push_back(32'd3);
        burst_len = 3'd3; start = 1'b1;
        done_at = 0; dones = 0; probes = 0; prev_probe = 1'b0;
        for (int j = 1; j <= 120; j++) begin
            tick(1);
            start = 1'b0;
            if (probe && !prev_probe) probes++;
            if (!probe && prev_probe && exp_q.size() > 0)
                chk("burst cycles_done", 32'(cycles_done), exp_q.pop_front());
            prev_probe = probe;
            if (done) begin
                dones++;
                if (done_at == 0) done_at = j;
            end
            if (done_at != 0 && j > done_at + 3) break;
        end
        chk("burst queue drained", 32'(exp_q.size()), 32'd0);
        chk("burst probes", 32'(probes), 32'd3);
        chk("burst done count", 32'(dones), 32'd1);
        chk("burst done time", 32'(done_at), 32'd57);
        chk("burst cycles_done", 32'(cycles_done), 32'd3);
        chk("burst timer_reset", 32'(timer_reset), 32'd1);
        chk("burst pump", 32'(pump), 32'd0);
        chk("burst state", 32'(state_dbg), 32'(ST_IDLE));

        // stop during the first MW pulse: that cycle finishes, then done
        burst_len = 3'd0; start = 1'b1;
        done_at = 0; dones = 0; probes = 0; mw_cycles = 0; stop_j = 0; prev_probe = 1'b0;
        for (int j = 1; j <= 60; j++) begin
            tick(1);
            start = 1'b0; stop = 1'b0;
            if (stop_j != 0 && j == stop_j + 1)
                chk("stop enters drain", 32'(state_dbg), 32'(ST_DRAIN));
            if (MW) mw_cycles++;
            if (MW && stop_j == 0) begin
                stop = 1'b1;
                stop_j = j;
            end
            if (probe && !prev_probe) probes++;
            prev_probe = probe;
            if (done) begin
                dones++;
                if (done_at == 0) done_at = j;
            end
            if (done_at != 0 && j > done_at + 2) break;
        end
        chk("stop mw cycles", 32'(mw_cycles), 32'd4);
        chk("stop probes", 32'(probes), 32'd1);
        chk("stop cycles_done", 32'(cycles_done), 32'd1);
        chk("stop done time", 32'(done_at), 32'd17);
        chk("stop done count", 32'(dones), 32'd1);
        chk("stop state", 32'(state_dbg), 32'(ST_IDLE));

        // continuous run saturates at 7, then stop drains one more cycle
        burst_len = 3'd0; start = 1'b1; dones = 0;
        for (int j = 1; j <= 200; j++) begin
            tick(1);
            start = 1'b0;
            if (done) dones++;
        end
        chk("sat cycles_done", 32'(cycles_done), 32'd7);
        chk("sat running", 32'(running), 32'd1);
        chk("sat no done", 32'(dones), 32'd0);
        stop = 1'b1;
        for (int j = 1; j <= 40; j++) begin
            tick(1);
            stop = 1'b0;
            if (done) begin
                dones++;
                break;
            end
        end
        chk("sat drain done", 32'(dones), 32'd1);
        chk("sat drain cycles_done", 32'(cycles_done), 32'd7);
        tick(1);
        chk("sat done one cycle", 32'(done), 32'd0);
        chk("sat idle", 32'(state_dbg), 32'(ST_IDLE));

        // pump & MW overlap
        start = 1'b1;
        for (int j = 1; j <= 30; j++) begin
            tick(1);
            start = 1'b0;
            if (pump) break;
        end
        chk("overlap wait pump", 32'(pump), 32'd1);
        force_mw = 1'b1;
        tick(1);
        force_mw = 1'b0;
        chk("overlap pins", {28'd0, pump, probe, MW, sample}, 32'd0);
        chk("overlap fault", 32'(fault), 32'd1);
        chk("overlap code", 32'(fault_code), 32'd1);
        chk("overlap timer_reset", 32'(timer_reset), 32'd1);
        chk("overlap running", 32'(running), 32'd0);
        start = 1'b1;
        tick(1);
        start = 1'b0;
        chk("fault ignores start", 32'(state_dbg), 32'(ST_FAULT));
        chk("fault code holds", 32'(fault_code), 32'd1);
        pulse_fault_clear();
        chk("clear state", 32'(state_dbg), 32'(ST_IDLE));
        chk("clear code", 32'(fault_code), 32'd0);
        chk("clear fault", 32'(fault), 32'd0);

        // probe & MW overlap in the second cycle; cycles_done holds in FAULT
        start = 1'b1;
        for (int j = 1; j <= 60; j++) begin
            tick(1);
            start = 1'b0;
            if (probe && cycles_done == 3'd1) break;
        end
        chk("probe overlap wait", {31'd0, probe}, 32'd1);
        force_mw = 1'b1;
        tick(1);
        force_mw = 1'b0;
        chk("probe overlap code", 32'(fault_code), 32'd2);
        chk("probe overlap MW pin", 32'(MW), 32'd0);
        tick(2);
        chk("fault cycles_done holds", 32'(cycles_done), 32'd1);
        pulse_fault_clear();

        // watchdog: probe never falls, fault after 50 RUN cycles
        hold_probe_low = 1'b1; start = 1'b1; fault_at = 0;
        for (int j = 1; j <= 80; j++) begin
            tick(1);
            start = 1'b0;
            if (fault) begin
                fault_at = j;
                break;
            end
        end
        chk("watchdog time", 32'(fault_at), 32'd52);
        chk("watchdog code", 32'(fault_code), 32'd4);
        chk("watchdog pins", {28'd0, pump, probe, MW, sample}, 32'd0);
        hold_probe_low = 1'b0;
        pulse_fault_clear();

        // start and stop together: stop wins
        start = 1'b1; stop = 1'b1;
        tick(1);
        start = 1'b0; stop = 1'b0;
        chk("start+stop state", 32'(state_dbg), 32'(ST_IDLE));
        chk("start+stop timer_reset", 32'(timer_reset), 32'd1);

        // stop in ARM: back to IDLE with no done
        start = 1'b1;
        tick(1);
        start = 1'b0;
        chk("arm state", 32'(state_dbg), 32'(ST_ARM));
        chk("arm timer_reset", 32'(timer_reset), 32'd0);
        chk("arm running", 32'(running), 32'd1);
        stop = 1'b1;
        tick(1);
        stop = 1'b0;
        chk("arm stop state", 32'(state_dbg), 32'(ST_IDLE));
        chk("arm stop done", 32'(done), 32'd0);
        chk("arm stop timer_reset", 32'(timer_reset), 32'd1);
        tick(1);
        chk("arm stop done later", 32'(done), 32'd0);

        // reset mid-run
        start = 1'b1;
        tick(1);
        start = 1'b0;
        tick(24);
        chk("pre-reset cycles_done", 32'(cycles_done), 32'd1);
        chk("pre-reset pump", 32'(pump), 32'd1);
        reset = 1'b1;
        tick(1);
        chk_reset_values("mid-run reset");
        reset = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
